// File: rtl/hack_pkg.sv
// hack_pkg: shared constants and types for the Hack CPU program-counter slice.
// Used by hack_jump_cond (also reused by the CPU decode stage) and hack_pc.
package hack_pkg;

   // Datapath width of the PC and of the jump target word
   localparam int HACK_WIDTH = 16;

   // Address the PC is forced to while reset is sampled high
   localparam logic [HACK_WIDTH-1:0] HACK_RESET_VECTOR = 16'h0000;

   // Bit positions of the jump field {j1,j2,j3} = instr[2:0]
   localparam int J1_LT = 2;   // jump when ALU result < 0
   localparam int J2_EQ = 1;   // jump when ALU result == 0
   localparam int J3_GT = 0;   // jump when ALU result > 0

   // Width of the optional taken-jump counter
   localparam int HACK_JCOUNT_WIDTH = 16;

   // Per-edge action selected by the PC priority logic (reset handled separately)
   typedef enum logic [1:0] {
      PC_HOLD_HALT  = 2'd0,
      PC_HOLD_STALL = 2'd1,
      PC_LOAD       = 2'd2,
      PC_INCR       = 2'd3
   } pc_action_e;

   // Saturating increment for the optional jump counter
   function automatic logic [HACK_JCOUNT_WIDTH-1:0] sat_inc16(
      input logic [HACK_JCOUNT_WIDTH-1:0] value
   );
      logic [HACK_JCOUNT_WIDTH-1:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'h0001;
      end
      return result;
   endfunction

endpackage : hack_pkg

// File: rtl/hack_jump_cond.sv
// hack_jump_cond: purely combinational evaluation of the C-instruction jump
// field against the ALU flags. A-instructions never jump. Shared with the
// CPU decode stage, so it carries no state and no clock.
module hack_jump_cond
   import hack_pkg::*;
(
   input  logic [2:0] jmp,
   input  logic       zr,
   input  logic       ng,
   input  logic       is_cinstr,
   output logic       take
);

   logic w_lt;
   logic w_eq;
   logic w_gt;

   // Decode the three ALU relations from the flags and gate with the jump bits
   always_comb begin
      w_lt = 1'b0;
      w_eq = 1'b0;
      w_gt = 1'b0;
      take = 1'b0;
      if (is_cinstr) begin
         w_lt = jmp[J1_LT] & ng;
         w_eq = jmp[J2_EQ] & zr;
         w_gt = jmp[J3_GT] & ~zr & ~ng;
         take = w_lt | w_eq | w_gt;
      end else begin
         take = 1'b0;
      end
   end

endmodule : hack_jump_cond

// File: rtl/hack_pc.sv
// hack_pc: program counter stage of the Hack CPU.
// Loads the jump target, increments or holds the instruction address, and
// latches a sticky halt flag when a taken jump targets the current address.
// Every output is registered; reset is synchronous and active-high.
// Optional build macro: HACK_PC_JUMP_COUNT_EN adds a saturating 16-bit count
// of taken jumps on output jump_count.
module hack_pc
   import hack_pkg::*;
#(
   parameter int                WIDTH        = HACK_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = HACK_RESET_VECTOR
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             inc_en,
   input  logic             is_cinstr,
   input  logic [2:0]       jmp,
   input  logic             zr,
   input  logic             ng,
   output logic [WIDTH-1:0] out,
   output logic             jump_taken,
   output logic             halted
`ifdef HACK_PC_JUMP_COUNT_EN
   ,
   output logic [HACK_JCOUNT_WIDTH-1:0] jump_count
`endif
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_out;
   logic             r_jump_taken;
   logic             r_halted;

   logic             w_take;
   logic             w_self_jump;
   pc_action_e       w_action;
   logic [WIDTH-1:0] w_out_nxt;
   logic             w_jump_taken_nxt;
   logic             w_halted_nxt;

   hack_jump_cond u_jump_cond (
      .jmp       (jmp),
      .zr        (zr),
      .ng        (ng),
      .is_cinstr (is_cinstr),
      .take      (w_take)
   );

   // A taken jump whose target equals the current PC is the canonical halt loop
   always_comb begin
      w_self_jump = 1'b0;
      if (in == r_out) begin
         w_self_jump = 1'b1;
      end else begin
         w_self_jump = 1'b0;
      end
   end

   // Priority select: halted, then stall, then jump, then increment
   always_comb begin
      w_action = PC_INCR;
      if (r_halted) begin
         w_action = PC_HOLD_HALT;
      end else if (!inc_en) begin
         w_action = PC_HOLD_STALL;
      end else if (w_take) begin
         w_action = PC_LOAD;
      end else begin
         w_action = PC_INCR;
      end
   end

   // Next-state values for the PC, jump pulse and halt flag
   always_comb begin
      w_out_nxt        = r_out;
      w_jump_taken_nxt = 1'b0;
      w_halted_nxt     = r_halted;
      case (w_action)
         PC_HOLD_HALT: begin
            w_out_nxt        = r_out;
            w_jump_taken_nxt = 1'b0;
            w_halted_nxt     = 1'b1;
         end
         PC_HOLD_STALL: begin
            // a jump presented during a stall is dropped, not queued
            w_out_nxt        = r_out;
            w_jump_taken_nxt = 1'b0;
            w_halted_nxt     = r_halted;
         end
         PC_LOAD: begin
            w_out_nxt        = in;
            w_jump_taken_nxt = 1'b1;
            w_halted_nxt     = r_halted | w_self_jump;
         end
         PC_INCR: begin
            // natural modulo-2^WIDTH wrap, no flag
            w_out_nxt        = r_out + ONE;
            w_jump_taken_nxt = 1'b0;
            w_halted_nxt     = r_halted;
         end
         default: begin
            w_out_nxt        = r_out;
            w_jump_taken_nxt = 1'b0;
            w_halted_nxt     = r_halted;
         end
      endcase
   end

   // PC, jump pulse and sticky halt registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out        <= RESET_VECTOR;
         r_jump_taken <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_out        <= w_out_nxt;
         r_jump_taken <= w_jump_taken_nxt;
         r_halted     <= w_halted_nxt;
      end
   end

   assign out        = r_out;
   assign jump_taken = r_jump_taken;
   assign halted     = r_halted;

`ifdef HACK_PC_JUMP_COUNT_EN
   logic [HACK_JCOUNT_WIDTH-1:0] r_jump_count;
   logic [HACK_JCOUNT_WIDTH-1:0] w_jump_count_nxt;

   // Count edges that raise the jump pulse; saturate, hold when halted or stalled
   always_comb begin
      w_jump_count_nxt = r_jump_count;
      if (w_jump_taken_nxt) begin
         w_jump_count_nxt = sat_inc16(r_jump_count);
      end else begin
         w_jump_count_nxt = r_jump_count;
      end
   end

   // Jump counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_jump_count <= 16'h0000;
      end else begin
         r_jump_count <= w_jump_count_nxt;
      end
   end

   assign jump_count = r_jump_count;
`endif

endmodule : hack_pc

// File: tb/tb_hack_pc.sv
// tb_hack_pc: scoreboard bench for hack_pc. The driver applies one input set
// per cycle, advances a behavioural model and queues the expected outputs;
// an independent monitor pops and compares after each rising edge.
module tb_hack_pc;
   import hack_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] s_in = 16'h0000;
   logic        inc_en = 1'b0;
   logic        is_cinstr = 1'b0;
   logic [2:0]  jmp = 3'b000;
   logic        zr = 1'b0;
   logic        ng = 1'b0;
   logic [15:0] s_out;
   logic        s_jump_taken;
   logic        s_halted;
`ifdef HACK_PC_JUMP_COUNT_EN
   logic [15:0] s_jump_count;
`endif

   always #5 clk = ~clk;

   hack_pc dut (
      .clk        (clk),
      .reset      (reset),
      .in         (s_in),
      .inc_en     (inc_en),
      .is_cinstr  (is_cinstr),
      .jmp        (jmp),
      .zr         (zr),
      .ng         (ng),
      .out        (s_out),
      .jump_taken (s_jump_taken),
      .halted     (s_halted)
`ifdef HACK_PC_JUMP_COUNT_EN
      ,
      .jump_count (s_jump_count)
`endif
   );

   typedef struct {
      logic [15:0] pc;
      logic        jt;
      logic        h;
      logic [15:0] cnt;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // behavioural model state
   int   m_pc  = 0;
   bit   m_h   = 1'b0;
   int   m_cnt = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   // One cycle of stimulus plus the model's prediction of the resulting outputs
   task automatic step(input bit rst, input bit inc, input bit isc, input logic [2:0] j,
                       input bit z, input bit n, input int a, input string tag);
      exp_t e;
      bit   take;
      @(negedge clk);
      reset = rst; inc_en = inc; is_cinstr = isc; jmp = j; zr = z; ng = n;
      s_in = a[15:0];
      // jump rule: j1 on negative, j2 on zero, j3 on strictly positive
      take = isc && ((j[2] && n) || (j[1] && z) || (j[0] && !z && !n));
      e.jt = 1'b0;
      if (rst) begin
         m_pc = int'(HACK_RESET_VECTOR); m_h = 1'b0; m_cnt = 0;
      end else if (m_h || !inc) begin
         m_pc = m_pc;
      end else if (take) begin
         if (a == m_pc) m_h = 1'b1;
         m_pc = a;
         e.jt = 1'b1;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
         m_pc = (m_pc + 1) % 65536;
      end
      e.pc = m_pc[15:0]; e.h = m_h; e.cnt = m_cnt[15:0]; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic jump_to(input int a);
      step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, a, "preload");
   endtask

   // Monitor: after every rising edge, compare the DUT against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.tag, ".out"}, s_out, e.pc);
            chk({e.tag, ".jump_taken"}, {15'd0, s_jump_taken}, {15'd0, e.jt});
            chk({e.tag, ".halted"}, {15'd0, s_halted}, {15'd0, e.h});
`ifdef HACK_PC_JUMP_COUNT_EN
            chk({e.tag, ".jump_count"}, s_jump_count, e.cnt);
`endif
         end
      end
   end

   initial begin
      int a;
      // reset and plain increment
      step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0, "reset");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0777, "inc");

      // conditional jumps from 0x0010 toward 0x0100
      jump_to(16'h0010);
      step(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 16'h0100, "jgt_take");
      jump_to(16'h0010);
      step(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 16'h0100, "jgt_neg");
      jump_to(16'h0010);
      step(1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0100, "jeq_take");
      jump_to(16'h0010);
      step(1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 16'h0100, "jnull");

      // A-instruction never jumps
      jump_to(16'h0005);
      step(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0200, "a_mask");

      // stall (with a jump offered and dropped) then wrap
      jump_to(16'hFFFF);
      step(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h1234, "stall");
      step(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h1234, "stall");
      step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h1234, "wrap");

      // halt loop
      jump_to(16'h0020);
      step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0020, "halt_set");
      step(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0300, "halt_hold");
      step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0300, "halt_hold_inc");
      step(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0300, "halt_reset");

      // three taken jumps, then reset together with a take
      jump_to(16'h0040);
      jump_to(16'h0050);
      jump_to(16'h0060);
      step(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0070, "rst_take");

      // randomized traffic, with targets sometimes equal to the current PC
      for (int i = 0; i < 600; i++) begin
         a = ($urandom_range(0, 7) == 0) ? m_pc : int'($urandom_range(0, 65535));
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, "rand");
      end

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_hack_pc

// File: doc/hack_pc.md
Name: hack_pc

Overview:
- Program counter stage of the Hack CPU.
- Consumes the 16-bit A-register / ALU-selected word produced by the upstream mux16 stage as its jump target.
- Evaluates the C-instruction jump field against the ALU flags, then loads, increments or holds the instruction address.
- Detects the canonical self-jump halt loop and feeds ROM32K addressing.

Parameters:
- WIDTH, 16, address/data width of PC and target.
- RESET_VECTOR, 16'h0000, value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  jump target (upstream mux16 output / A register)
- inc_en  input  1  advance enable; 0 = stall and hold PC
- is_cinstr  input  1  current instruction is a C-instruction (instr[15])
- jmp  input  3  jump bits {j1,j2,j3} = instr[2:0]
- zr  input  1  ALU zero flag
- ng  input  1  ALU negative flag
- out  output  WIDTH  current PC, registered
- jump_taken  output  1  registered pulse: the previous edge performed a load
- halted  output  1  sticky: a self-jump loop was detected

Behaviour:
- All outputs are registered. Update on rising clk only. No combinational path from any input to any output.
- Reset (sampled at the edge) forces out=RESET_VECTOR, jump_taken=0, halted=0. Reset overrides every other input, including mid-stall and while halted.
- Jump condition (combinational, internal):
  - take = is_cinstr & ((j1&ng) | (j2&zr) | (j3&~zr&~ng))
  - jmp=3'b000 never jumps; jmp=3'b111 always jumps when is_cinstr=1.
  - is_cinstr=0 (A-instruction) never jumps, whatever jmp is.
- Update priority per edge, highest first:
  1. reset
  2. halted=1: out holds, jump_taken=0
  3. inc_en=0: out holds, jump_taken=0; a pending jump is NOT remembered
  4. take=1: out<=in, jump_taken<=1
  5. otherwise: out<=out+1 modulo 2^WIDTH, jump_taken<=0
- Wrap-around: out=16'hFFFF with increment gives 16'h0000. There is no flag and no error.
- Halt detect: on an edge where inc_en=1, halted=0 and take=1 with in==out, halted<=1 at that same edge. out<=in, so the value is unchanged, and jump_taken<=1 for that single edge. From the next edge, halted=1 keeps jump_taken at 0.
- halted clears only on reset.
- Latency: decision is made from the inputs in cycle N. out shows the new address in cycle N+1. jump_taken is high during N+1 only.
- Simultaneous reset and take: reset wins, and jump_taken=0.

Optional Feature:
- Macro: HACK_PC_JUMP_COUNT_EN
- When defined:
  - Adds output jump_count [15:0], registered, reset to 0.
  - Increments on every edge where jump_taken is set to 1.
  - Saturates at 16'hFFFF.
  - Holds while halted or stalled.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- hack_pkg holds:
  - HACK_WIDTH=16
  - HACK_RESET_VECTOR
  - jump-bit index constants J1_LT=2, J2_EQ=1, J3_GT=0
- One sub-module, hack_jump_cond: purely combinational (jmp, zr, ng, is_cinstr) -> take. It is reused by the CPU decode stage.
- The PC register, priority logic, halt detect and optional counter live in hack_pc.

Test Plan:
- Reset and increment: reset=1 for one edge -> out=0x0000. Then inc_en=1, is_cinstr=0 for 3 edges -> out=0x0001, 0x0002, 0x0003, jump_taken=0 throughout.
- Conditional jumps, each from out=0x0010, in=0x0100:
  - jmp=3'b001 (JGT), zr=0, ng=0 -> out=0x0100, jump_taken=1 for one cycle.
  - jmp=3'b001, ng=1 -> out=0x0011.
  - jmp=3'b010 (JEQ), zr=1 -> out=0x0100.
  - jmp=3'b000, any flags -> out=0x0011.
- A-instruction masking: is_cinstr=0, jmp=3'b111, in=0x0200, out=0x0005 -> out=0x0006, jump_taken=0.
- Stall and wrap:
  - Preload out=0xFFFF via jump, then inc_en=0 for 2 edges -> out stays 0xFFFF.
  - inc_en=1 -> out=0x0000.
- Halt loop:
  - out=0x0020, in=0x0020, is_cinstr=1, jmp=3'b111 -> halted=1 and jump_taken=1 on the next cycle.
  - Then in=0x0300, jmp=3'b111 -> out stays 0x0020, jump_taken=0.
  - reset -> out=0x0000, halted=0.
- Reset priority with HACK_PC_JUMP_COUNT_EN:
  - 3 taken jumps -> jump_count=3.
  - reset asserted together with take=1 -> out=0x0000, jump_taken=0, jump_count=0.
